rand_draw_arbiter: RTL and testbench
====================================

// Module: rand_draw_arbiter
// PURPOSE
//  Shares the single 10-bit pseudo-random source between N requesters (obstacle size/position
//  during map generation, pickup placement during play). Grants one requester at a time
//  round-robin, draws an unbiased value in [0, bound] by masked rejection sampling, and returns
//  it with a one-cycle response pulse. Sits between the random generator and the game-FSM clients.
// PARAMETERS
//  N          4   number of requesters (2..8)
//  MAX_RETRY  4   rejected samples allowed before the deterministic fallback (1..15)
// PORTS
//  Clk        in   1     system clock; all state updates on posedge
//  Reset_n    in   1     asynchronous, active-low reset
//  rand_in    in   10    current value of the free-running 10-bit random generator
//  req        in   N     per-requester draw request; level, held until own response
//  bound_flat in   N*10  requester i bound at [10*i+9:10*i]; result range is 0..bound
//  grant      out  N     one-hot; requester currently being served
//  rsp_valid  out  1     one-cycle pulse; rsp_value/rsp_id valid
//  rsp_value  out  10    drawn value, always <= latched bound
//  rsp_id     out  3     index of served requester
// BEHAVIOUR
//  Reset (async, Reset_n=0): state=IDLE, grant=0, rsp_valid=0, rsp_value=0, rsp_id=0,
//   rr pointer=0, retry count=0.
//  States: IDLE, SAMPLE, RESP.
//  IDLE: if |req, pick first set bit searching upward from rr pointer (wrapping at N-1->0);
//   latch id, bound_i, mask = smallest 2^k-1 >= bound_i (bound 0 -> mask 0); retry=0;
//   grant<=onehot(id); -> SAMPLE. No req -> stay.
//  SAMPLE: cand = rand_in & mask.
//   cand <= bound -> rsp_value<=cand, -> RESP.
//   else if retry == MAX_RETRY-1 -> rsp_value<=cand-(bound+1) (fits: cand<2*(bound+1)), -> RESP.
//   else retry<=retry+1, stay (new rand_in sampled next cycle).
//  RESP: rsp_valid=1 for exactly this cycle, rsp_id=id, grant held; rr pointer<=(id+1) mod N;
//   grant<=0; -> IDLE.
//  Latency: req seen in IDLE at cycle t -> grant at t+1 -> rsp_valid at t+2 best case,
//   t+1+MAX_RETRY+... worst case = t+2+(MAX_RETRY-1). Min back-to-back spacing 3 cycles.
//  Requester must deassert req the cycle after its rsp_valid or it re-enters arbitration
//   (it loses priority to all others via the pointer, so no starvation).
//  req dropped mid-service: service completes, rsp_valid still pulses; requester ignores it.
//  bound_flat changes after grant are ignored (bound latched in IDLE).
//  bound=1023: mask=1023, always accepted first sample. bound=0: result 0, one SAMPLE cycle.
//  Simultaneous requests: only one granted; others wait; order strictly round-robin.
//  Reset mid-operation: immediate return to reset values; in-flight draw discarded, no rsp.
//  All arithmetic 10-bit unsigned; cand-(bound+1) computed 11-bit, low 10 bits used.
// STRUCTURE
//  rand_arb_pkg: RAND_W=10 localparam, state_t enum {IDLE,SAMPLE,RESP},
//   function ceil_mask(bound) returning smallest all-ones mask >= bound.
//  Sub-module rr_picker: combinational round-robin priority encoder (req, ptr -> id, any).
//  Top holds FSM, latched bound/mask/id, retry counter, output registers.
// TESTING
//  1 Reset: Reset_n=0 mid-SAMPLE -> grant=0, rsp_valid=0, state IDLE same cycle (async).
//  2 Single req[0], bound=37, rand_in=0x025 -> grant=0001 at t+1, rsp_value=37, rsp_id=0 at t+2.
//  3 bound=100 (mask 127), rand_in held 0x0FF for MAX_RETRY=4 samples -> fallback
//    127-101=26 returned after 4 SAMPLE cycles.
//  4 req=1111 held, ptr=0 -> rsp_id sequence 0,1,2,3,0; each rsp_valid exactly one cycle.
//  5 bound=0 -> rsp_value=0; bound=1023, rand_in=0x3FF -> rsp_value=1023, no retry.
//  6 Random: 10k draws, random bounds/rand_in -> every rsp_value<=bound, no lost/duplicate grants.

Source files
------------

// File: rtl/rand_arb_pkg.sv
// Shared types and helpers for the random-draw arbiter.
package rand_arb_pkg;

  localparam int RAND_W = 10;

  typedef enum logic [1:0] {IDLE, SAMPLE, RESP} state_t;

  // Smallest all-ones mask covering bound; bound 0 yields 0.
  function automatic logic [RAND_W-1:0] ceil_mask(input logic [RAND_W-1:0] bound);
    logic [RAND_W-1:0] m;
    m = '0;
    for (int i = 0; i < RAND_W; i++) begin
      if (m < bound) m = {m[RAND_W-2:0], 1'b1};
    end
    return m;
  endfunction

endpackage

// File: rtl/rand_draw_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first requester at or above ptr, wrapping.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [2:0]   id,
  output logic         any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [3:0]     pos;

  // Doubling the vector lets a plain shift implement the wrap-around rotation.
  assign dbl = {req, req};
  assign rot = N'(dbl >> ptr);
  assign any = |req;

  always_comb begin
    id  = '0;
    pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos = {1'b0, ptr} + 4'(k);
        if (pos >= 4'(N)) pos = pos - 4'(N);
        id = pos[2:0];
      end
    end
  end

endmodule

// File: rtl/rand_draw_arbiter.sv
// Round-robin arbiter sharing one random source; draws unbiased values in [0, bound]
// by masked rejection sampling with a bounded retry count and deterministic fallback.
module rand_draw_arbiter
  import rand_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_RETRY = 4
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [RAND_W-1:0]   rand_in,
  input  logic [N-1:0]        req,
  input  logic [N*RAND_W-1:0] bound_flat,
  output logic [N-1:0]        grant,
  output logic                rsp_valid,
  output logic [RAND_W-1:0]   rsp_value,
  output logic [2:0]          rsp_id
);

  localparam logic [3:0]        RETRY_LAST = 4'(MAX_RETRY - 1);
  localparam logic [RAND_W-1:0] ONE        = RAND_W'(1);

  state_t            state_reg, state_next;
  logic [2:0]        ptr_reg, ptr_next;
  logic [2:0]        id_reg, id_next;
  logic [RAND_W-1:0] bound_reg, bound_next;
  logic [RAND_W-1:0] mask_reg, mask_next;
  logic [3:0]        retry_reg, retry_next;
  logic [N-1:0]      grant_next;
  logic              valid_next;
  logic [RAND_W-1:0] value_next;
  logic [2:0]        rspid_next;

  logic [RAND_W-1:0] bounds [N];
  logic [N-1:0]      pick_onehot;
  logic [RAND_W-1:0] pick_bound;
  logic [2:0]        pick_id;
  logic              pick_any;
  logic [RAND_W-1:0] cand;
  logic [RAND_W-1:0] fallback;

  rr_picker #(.N(N)) u_picker (
    .req (req),
    .ptr (ptr_reg),
    .id  (pick_id),
    .any (pick_any)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    assign bounds[gi]      = bound_flat[gi*RAND_W +: RAND_W];
    assign pick_onehot[gi] = (pick_id == 3'(gi));
  end

  always_comb begin
    pick_bound = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_id == 3'(i)) pick_bound = bounds[i];
    end
  end

  // cand < 2*(bound+1) whenever it is rejected, so one subtraction lands in range.
  assign cand     = rand_in & mask_reg;
  assign fallback = cand - bound_reg - ONE;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    id_next    = id_reg;
    bound_next = bound_reg;
    mask_next  = mask_reg;
    retry_next = retry_reg;
    grant_next = grant;
    valid_next = 1'b0;
    value_next = rsp_value;
    rspid_next = rsp_id;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          id_next    = pick_id;
          bound_next = pick_bound;
          mask_next  = ceil_mask(pick_bound);
          retry_next = '0;
          grant_next = pick_onehot;
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        if (cand <= bound_reg) begin
          value_next = cand;
          rspid_next = id_reg;
          valid_next = 1'b1;
          state_next = RESP;
        end else if (retry_reg == RETRY_LAST) begin
          value_next = fallback;
          rspid_next = id_reg;
          valid_next = 1'b1;
          state_next = RESP;
        end else begin
          retry_next = retry_reg + 4'd1;
        end
      end
      RESP: begin
        ptr_next   = (id_reg == 3'(N - 1)) ? 3'd0 : id_reg + 3'd1;
        grant_next = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      id_reg    <= '0;
      bound_reg <= '0;
      mask_reg  <= '0;
      retry_reg <= '0;
      grant     <= '0;
      rsp_valid <= 1'b0;
      rsp_value <= '0;
      rsp_id    <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      id_reg    <= id_next;
      bound_reg <= bound_next;
      mask_reg  <= mask_next;
      retry_reg <= retry_next;
      grant     <= grant_next;
      rsp_valid <= valid_next;
      rsp_value <= value_next;
      rsp_id    <= rspid_next;
    end
  end

endmodule

// File: tb/tb_rand_draw_arbiter.sv
// Bench for rand_draw_arbiter: transaction-level reference model, directed cases, random draws.
module tb_rand_draw_arbiter;

  localparam int N           = 4;
  localparam int MAX_RETRY   = 4;
  localparam int W           = 10;
  localparam int TAB         = 80016;
  localparam int CYC_LIMIT   = 80000;
  localparam int RAND_TARGET = 10000;

  logic           Clk = 1'b0;
  logic           Reset_n = 1'b0;
  logic [W-1:0]   rand_in = '0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] bound_flat = '0;
  logic [N-1:0]   grant;
  logic           rsp_valid;
  logic [W-1:0]   rsp_value;
  logic [2:0]     rsp_id;

  rand_draw_arbiter #(.N(N), .MAX_RETRY(MAX_RETRY)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .rand_in    (rand_in),
    .req        (req),
    .bound_flat (bound_flat),
    .grant      (grant),
    .rsp_valid  (rsp_valid),
    .rsp_value  (rsp_value),
    .rsp_id     (rsp_id)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_draws = 0;
  logic [W-1:0] rnd_tab [TAB];

  // Model state: one draw in flight, its whole outcome resolved when it is granted.
  bit m_busy = 1'b0;
  int m_ptr = 0, m_w = 0, m_b = 0, m_val = 0, m_start = 0, m_end = 0;

  int ids[$];
  int exp_ids [5] = '{0, 1, 2, 3, 0};
  int base_draws;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic set_rnd(input int off, input logic [W-1:0] v);
    rnd_tab[cyc + off] = v;
    if (off == 0) rand_in = v;
  endtask

  function automatic logic [W-1:0] rand_bound();
    int k;
    k = int'($urandom_range(0, 9));
    case ($urandom_range(0, 3))
      0: return W'($urandom_range(0, 7));
      1: return W'($urandom_range(0, 1023));
      2: return W'(((1 << k) - 1) + int'($urandom_range(0, 1)));
      default: return ($urandom_range(0, 1) == 0) ? 10'd0 : 10'd1023;
    endcase
  endfunction

  // Resolve the edge at cycle cyc from the spec rules using the known rand_in schedule.
  task automatic model_edge();
    int w, i, b, mask, c, kb;
    if (m_busy) begin
      if (cyc == m_end + 1) m_busy = 1'b0;
    end else if (req != '0) begin
      w = -1;
      for (int off = 0; off < N; off++) begin
        i = (m_ptr + off) % N;
        if (w < 0 && req[i]) w = i;
      end
      b = int'(bound_flat[w*W +: W]);
      kb = 0;
      while ((1 << kb) < b + 1) kb++;
      mask = (1 << kb) - 1;
      m_end = -1;
      c = 0;
      for (int j = 1; j <= MAX_RETRY; j++) begin
        c = int'(rnd_tab[cyc + j]) & mask;
        if (m_end < 0 && c <= b) begin
          m_val = c;
          m_end = cyc + j;
        end
      end
      if (m_end < 0) begin
        m_val = (c - (b + 1)) & 1023;
        m_end = cyc + MAX_RETRY;
      end
      m_busy  = 1'b1;
      m_w     = w;
      m_b     = b;
      m_start = cyc;
      m_ptr   = (w + 1) % N;
    end
  endtask

  task automatic compare();
    int  eg;
    bit  ev;
    eg = m_busy ? (1 << m_w) : 0;
    ev = m_busy && (cyc == m_end);
    chk("grant", int'(grant), eg);
    chk("rsp_valid", int'(rsp_valid), int'(ev));
    if (ev) begin
      chk("rsp_value", int'(rsp_value), m_val);
      chk("rsp_id", int'(rsp_id), m_w);
      chk("value_le_bound", int'(int'(rsp_value) <= m_b), 1);
      n_draws++;
      $display("draw id=%0d bound=%0d value=%0d latency=%0d", m_w, m_b, int'(rsp_value),
               m_end - m_start + 1);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
    model_edge();
    compare();
    cyc++;
    rand_in = rnd_tab[cyc];
  endtask

  // Asserted between edges so the asynchronous clear is observable before any clock.
  task automatic apply_reset();
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_value", int'(rsp_value), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    m_busy = 1'b0;
    m_ptr  = 0;
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc++;
    rand_in = rnd_tab[cyc];
  endtask

  initial begin
    for (int i = 0; i < TAB; i++) rnd_tab[i] = W'($urandom);
    rand_in = rnd_tab[0];
    @(negedge Clk);
    apply_reset();

    // Single request, first sample accepted; late bound change ignored.
    bound_flat[0*W +: W] = 10'd37;
    set_rnd(1, 10'h025);
    req = 4'b0001;
    step();
    chk("t2_grant", int'(grant), 1);
    bound_flat[0*W +: W] = 10'd5;
    step();
    chk("t2_rsp_valid", int'(rsp_valid), 1);
    chk("t2_value", int'(rsp_value), 37);
    chk("t2_id", int'(rsp_id), 0);
    req = '0;
    step();

    // Every sample rejected: fallback 127 - 101 = 26 after four samples.
    bound_flat[1*W +: W] = 10'd100;
    for (int j = 1; j <= 4; j++) set_rnd(j, 10'h0FF);
    req = 4'b0010;
    step();
    chk("t3_grant", int'(grant), 2);
    repeat (3) step();
    chk("t3_still_sampling", int'(rsp_valid), 0);
    step();
    chk("t3_rsp_valid", int'(rsp_valid), 1);
    chk("t3_value", int'(rsp_value), 26);
    chk("t3_id", int'(rsp_id), 1);
    req = '0;
    step();

    // Bound extremes.
    bound_flat[2*W +: W] = 10'd0;
    set_rnd(1, 10'h3A5);
    req = 4'b0100;
    step();
    step();
    chk("t5_zero_valid", int'(rsp_valid), 1);
    chk("t5_zero_value", int'(rsp_value), 0);
    req = '0;
    step();
    bound_flat[3*W +: W] = 10'd1023;
    set_rnd(1, 10'h3FF);
    req = 4'b1000;
    step();
    step();
    chk("t5_max_valid", int'(rsp_valid), 1);
    chk("t5_max_value", int'(rsp_value), 1023);
    chk("t5_max_id", int'(rsp_id), 3);
    req = '0;
    step();

    // All requesting: strict rotation.
    for (int i = 0; i < N; i++) bound_flat[i*W +: W] = 10'd1023;
    req = 4'b1111;
    repeat (15) begin
      step();
      if (rsp_valid) ids.push_back(int'(rsp_id));
    end
    req = '0;
    chk("t4_count", ids.size(), 5);
    for (int i = 0; i < 5 && i < ids.size(); i++) chk("t4_order", ids[i], exp_ids[i]);
    step();

    // Reset in the middle of a retrying draw; pointer must restart at 0.
    bound_flat[0*W +: W] = 10'd100;
    for (int j = 1; j <= 4; j++) set_rnd(j, 10'h0FF);
    req = 4'b0001;
    step();
    step();
    req = '0;
    apply_reset();
    for (int i = 0; i < N; i++) bound_flat[i*W +: W] = 10'd1023;
    req = 4'b1111;
    step();
    chk("t1_grant_after_rst", int'(grant), 1);
    step();
    chk("t1_id_after_rst", int'(rsp_id), 0);
    req = '0;
    step();

    // Random traffic.
    base_draws = n_draws;
    while (n_draws - base_draws < RAND_TARGET && cyc < CYC_LIMIT) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (rsp_valid && int'(rsp_id) == i) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 1) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 499) == 0) req[i] = 1'b0;
        if ($urandom_range(0, 1) == 0) bound_flat[i*W +: W] = rand_bound();
      end
    end
    chk("random_draws_done", int'(n_draws - base_draws >= RAND_TARGET), 1);
    req = '0;
    repeat (8) step();
    chk("final_idle_grant", int'(grant), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
